// File: rtl/mem_access_ctrl_if.sv
// Request and data_mem bus bundle for mem_access_ctrl.
interface mem_access_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned DATA_W = 32;

    // datapath request side
    logic              Req;
    logic              Wr;
    logic [1:0]        Size;
    logic              Unsigned;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] WrData;
    logic              Busy;
    logic              Done;
    logic              Misalign;
    logic [DATA_W-1:0] RdData;

    // data_mem side
    logic [ADDR_W-1:0] Mem_Addr;
    logic              Mem_WrEn;
    logic [DATA_W-1:0] Mem_Din;
    logic [DATA_W-1:0] Mem_Dout;

    // controller view
    modport slave (
        input  Req, Wr, Size, Unsigned, Addr, WrData, Mem_Dout,
        output Busy, Done, Misalign, RdData, Mem_Addr, Mem_WrEn, Mem_Din
    );

    // datapath + memory environment view
    modport master (
        output Req, Wr, Size, Unsigned, Addr, WrData, Mem_Dout,
        input  Busy, Done, Misalign, RdData, Mem_Addr, Mem_WrEn, Mem_Din
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store controller in front of a word-only data_mem: byte/half loads
// with extension, byte/half stores by read-modify-write, alignment checks.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic                Clk,
    input  logic                Rst_n,
    mem_access_ctrl_if.slave    bus
);
    localparam int unsigned DATA_W = 32;
    localparam logic [1:0]  SZ_B   = 2'b00;
    localparam logic [1:0]  SZ_H   = 2'b01;
    localparam logic [1:0]  SZ_W   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        DONE = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              misalign_q, misalign_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;

    logic              req_misaligned;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] merged;

    // Alignment check on the incoming request.
    always_comb begin
        req_misaligned = 1'b0;
        case (bus.Size)
            SZ_B:    req_misaligned = 1'b0;
            SZ_H:    req_misaligned = bus.Addr[0];
            SZ_W:    req_misaligned = (bus.Addr[1:0] != 2'b00);
            default: req_misaligned = 1'b1;
        endcase
    end

    // Lane extraction/extension for loads and lane merge for sub-word stores.
    always_comb begin
        lane_b   = bus.Mem_Dout[{off_q, 3'b000} +: 8];
        lane_h   = bus.Mem_Dout[{off_q[1], 4'b0000} +: 16];
        load_ext = bus.Mem_Dout;
        merged   = bus.Mem_Dout;
        case (size_q)
            SZ_B: begin
                load_ext = {{24{~uns_q & lane_b[7]}}, lane_b};
                merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            SZ_H: begin
                load_ext = {{16{~uns_q & lane_h[15]}}, lane_h};
                merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
            end
            default: begin
                load_ext = bus.Mem_Dout;
                merged   = bus.Mem_Dout;
            end
        endcase
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        size_d     = size_q;
        uns_d      = uns_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        misalign_d = misalign_q;
        rd_data_d  = rd_data_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        case (state_q)
            IDLE: begin
                if (bus.Req) begin
                    wr_d    = bus.Wr;
                    size_d  = bus.Size;
                    uns_d   = bus.Unsigned;
                    off_d   = bus.Addr[1:0];
                    wdata_d = bus.WrData[15:0];
                    if (req_misaligned) begin
                        misalign_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        misalign_d = 1'b0;
                        mem_addr_d = {bus.Addr[ADDR_W-1:2], 2'b00};
                        if (bus.Wr && (bus.Size == SZ_W)) begin
                            mem_din_d = bus.WrData;
                            state_d   = WR;
                        end else begin
                            state_d   = RD;
                        end
                    end
                end
            end
            RD: begin
                if (wr_q) begin
                    mem_din_d = merged;
                    state_d   = WR;
                end else begin
                    rd_data_d = load_ext;
                    state_d   = DONE;
                end
            end
            WR: begin
                state_d = DONE;
            end
            DONE: begin
                misalign_d = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            wr_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            off_q      <= 2'b00;
            wdata_q    <= 16'h0000;
            misalign_q <= 1'b0;
            rd_data_q  <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            off_q      <= off_d;
            wdata_q    <= wdata_d;
            misalign_q <= misalign_d;
            rd_data_q  <= rd_data_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    // Status and write enable decode straight from the state register.
    assign bus.Busy     = (state_q != IDLE);
    assign bus.Done     = (state_q == DONE);
    assign bus.Mem_WrEn = (state_q == WR);
    assign bus.Misalign = misalign_q;
    assign bus.RdData   = rd_data_q;
    assign bus.Mem_Addr = mem_addr_q;
    assign bus.Mem_Din  = mem_din_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small word memory model.
module tb_mem_access_ctrl;
    localparam int unsigned ADDR_W = 32;

    logic        Clk;
    logic        Rst_n;
    int          vectors;
    int          miscompares;
    logic [31:0] mem [0:15];

    mem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // word memory: combinational read, write on clock when enabled
    assign bus.Mem_Dout = mem[bus.Mem_Addr[5:2]];
    always @(posedge Clk) begin
        if (bus.Mem_WrEn) mem[bus.Mem_Addr[5:2]] <= bus.Mem_Din;
    end

    // Issue one request from IDLE and observe it up to its Done (bounded).
    task automatic do_req(input logic wr, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic mis, output logic [31:0] rd,
                          output int wrcnt, output logic [31:0] din, output logic [31:0] maddr);
        lat = -1; mis = 1'bx; rd = 'x; wrcnt = 0; din = 'x; maddr = 'x;
        @(negedge Clk);
        bus.Req = 1'b1; bus.Wr = wr; bus.Size = size; bus.Unsigned = uns;
        bus.Addr = addr; bus.WrData = wdata;
        @(posedge Clk);
        #1 bus.Req = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge Clk);
            if (bus.Mem_WrEn) begin
                wrcnt++;
                din   = bus.Mem_Din;
                maddr = bus.Mem_Addr;
            end
            if (bus.Done) begin
                lat = c;
                mis = bus.Misalign;
                rd  = bus.RdData;
                break;
            end
        end
    endtask

    task automatic test_reset;
        Rst_n = 1'b0;
        bus.Req = 1'b0; bus.Wr = 1'b0; bus.Size = 2'b00; bus.Unsigned = 1'b0;
        bus.Addr = '0; bus.WrData = '0;
        repeat (2) @(negedge Clk);
        vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b exp 0", bus.Busy); end
        vectors++; if (bus.Done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %0b exp 0", bus.Done); end
        vectors++; if (bus.Misalign !== 1'b0) begin miscompares++; $display("FAIL reset_misalign got %0b exp 0", bus.Misalign); end
        vectors++; if (bus.Mem_WrEn !== 1'b0) begin miscompares++; $display("FAIL reset_wren got %0b exp 0", bus.Mem_WrEn); end
        vectors++; if (bus.RdData !== 32'h0) begin miscompares++; $display("FAIL reset_rddata got %h exp 0", bus.RdData); end
        vectors++; if (bus.Mem_Addr !== 32'h0) begin miscompares++; $display("FAIL reset_memaddr got %h exp 0", bus.Mem_Addr); end
        vectors++; if (bus.Mem_Din !== 32'h0) begin miscompares++; $display("FAIL reset_memdin got %h exp 0", bus.Mem_Din); end
        Rst_n = 1'b1;
        @(negedge Clk);
        vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_busy got %0b exp 0", bus.Busy); end
    endtask

    task automatic test_sw;
        int lat, wrcnt; logic mis; logic [31:0] rd, din, maddr;
        do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h87654321, lat, mis, rd, wrcnt, din, maddr);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL sw_latency got %0d exp 2", lat); end
        vectors++; if (wrcnt !== 1) begin miscompares++; $display("FAIL sw_wr_cycles got %0d exp 1", wrcnt); end
        vectors++; if (din !== 32'h87654321) begin miscompares++; $display("FAIL sw_din got %h exp 87654321", din); end
        vectors++; if (maddr !== 32'h4) begin miscompares++; $display("FAIL sw_memaddr got %h exp 4", maddr); end
        vectors++; if (mis !== 1'b0) begin miscompares++; $display("FAIL sw_misalign got %0b exp 0", mis); end
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL sw_rddata_held got %h exp 0", rd); end
    endtask

    task automatic test_loads;
        logic [1:0]  sz [5]  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
        logic        un [5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ad [5]  = '{32'h7, 32'h7, 32'h6, 32'h6, 32'h4};
        logic [31:0] ex [5]  = '{32'hFFFFFF87, 32'h00000087, 32'hFFFF8765, 32'h00008765, 32'h87654321};
        int lat, wrcnt; logic mis; logic [31:0] rd, din, maddr;
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, sz[i], un[i], ad[i], 32'h0, lat, mis, rd, wrcnt, din, maddr);
            vectors++; if (rd !== ex[i]) begin miscompares++; $display("FAIL load%0d_rddata got %h exp %h", i, rd, ex[i]); end
            vectors++; if (lat !== 2 || wrcnt !== 0) begin miscompares++; $display("FAIL load%0d_timing lat %0d wr %0d exp 2/0", i, lat, wrcnt); end
        end
    endtask

    task automatic test_sb;
        int lat, wrcnt; logic mis; logic [31:0] rd, din, maddr;
        do_req(1'b1, 2'b00, 1'b0, 32'h5, 32'h123456AB, lat, mis, rd, wrcnt, din, maddr);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL sb_latency got %0d exp 3", lat); end
        vectors++; if (wrcnt !== 1) begin miscompares++; $display("FAIL sb_wr_cycles got %0d exp 1", wrcnt); end
        vectors++; if (din !== 32'h8765AB21) begin miscompares++; $display("FAIL sb_din got %h exp 8765ab21", din); end
        vectors++; if (rd !== 32'h87654321) begin miscompares++; $display("FAIL sb_rddata_held got %h exp 87654321", rd); end
        do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat, mis, rd, wrcnt, din, maddr);
        vectors++; if (rd !== 32'h8765AB21) begin miscompares++; $display("FAIL sb_readback got %h exp 8765ab21", rd); end
    endtask

    task automatic test_misalign;
        logic        w  [3] = '{1'b1, 1'b0, 1'b0};
        logic [1:0]  sz [3] = '{2'b01, 2'b10, 2'b11};
        logic [31:0] ad [3] = '{32'h5, 32'h2, 32'h0};
        int lat, wrcnt; logic mis; logic [31:0] rd, din, maddr;
        for (int i = 0; i < 3; i++) begin
            do_req(w[i], sz[i], 1'b0, ad[i], 32'hDEADBEEF, lat, mis, rd, wrcnt, din, maddr);
            vectors++; if (lat !== 1) begin miscompares++; $display("FAIL mis%0d_latency got %0d exp 1", i, lat); end
            vectors++; if (mis !== 1'b1) begin miscompares++; $display("FAIL mis%0d_flag got %0b exp 1", i, mis); end
            vectors++; if (wrcnt !== 0) begin miscompares++; $display("FAIL mis%0d_wren got %0d exp 0", i, wrcnt); end
            vectors++; if (rd !== 32'h8765AB21) begin miscompares++; $display("FAIL mis%0d_rddata got %h exp 8765ab21", i, rd); end
        end
        vectors++; if (mem[1] !== 32'h8765AB21) begin miscompares++; $display("FAIL mis_mem got %h exp 8765ab21", mem[1]); end
        @(negedge Clk);
        vectors++; if (bus.Misalign !== 1'b0) begin miscompares++; $display("FAIL mis_clear got %0b exp 0", bus.Misalign); end
    endtask

    task automatic test_back_to_back;
        int lat, wrcnt; logic mis; logic [31:0] rd, din, maddr;
        logic [7:0] busy_s, done_s, wren_s;
        do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h11223344, lat, mis, rd, wrcnt, din, maddr);
        @(negedge Clk);
        bus.Req = 1'b1; bus.Wr = 1'b1; bus.Size = 2'b00; bus.Unsigned = 1'b0;
        bus.Addr = 32'h0; bus.WrData = 32'h000000EE;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            busy_s[i] = bus.Busy;
            done_s[i] = bus.Done;
            wren_s[i] = bus.Mem_WrEn;
        end
        bus.Req = 1'b0;
        vectors++; if (busy_s !== 8'b01110111) begin miscompares++; $display("FAIL b2b_busy got %b exp 01110111", busy_s); end
        vectors++; if (done_s !== 8'b01000100) begin miscompares++; $display("FAIL b2b_done got %b exp 01000100", done_s); end
        vectors++; if (wren_s !== 8'b00100010) begin miscompares++; $display("FAIL b2b_wren got %b exp 00100010", wren_s); end
        do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, lat, mis, rd, wrcnt, din, maddr);
        vectors++; if (rd !== 32'h112233EE) begin miscompares++; $display("FAIL b2b_readback got %h exp 112233ee", rd); end
    endtask

    task automatic test_reset_abort;
        int lat, wrcnt; logic mis; logic [31:0] rd, din, maddr;
        logic done_seen;
        do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'hCAFEF00D, lat, mis, rd, wrcnt, din, maddr);
        @(negedge Clk);
        bus.Req = 1'b1; bus.Wr = 1'b1; bus.Size = 2'b01; bus.Unsigned = 1'b0;
        bus.Addr = 32'h8; bus.WrData = 32'h0000BEEF;
        @(posedge Clk);
        #1 bus.Req = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        vectors++; if (bus.Mem_WrEn !== 1'b1) begin miscompares++; $display("FAIL abort_in_wr got %0b exp 1", bus.Mem_WrEn); end
        #2 Rst_n = 1'b0;
        #1;
        vectors++; if (bus.Mem_WrEn !== 1'b0) begin miscompares++; $display("FAIL abort_wren got %0b exp 0", bus.Mem_WrEn); end
        vectors++; if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin miscompares++; $display("FAIL abort_status busy %0b done %0b exp 0/0", bus.Busy, bus.Done); end
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        done_seen = 1'b0;
        repeat (4) begin
            @(negedge Clk);
            if (bus.Done) done_seen = 1'b1;
        end
        vectors++; if (done_seen !== 1'b0) begin miscompares++; $display("FAIL abort_no_done got %0b exp 0", done_seen); end
        vectors++; if (mem[2] !== 32'hCAFEF00D) begin miscompares++; $display("FAIL abort_mem got %h exp cafef00d", mem[2]); end
        do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, lat, mis, rd, wrcnt, din, maddr);
        vectors++; if (rd !== 32'hCAFEF00D) begin miscompares++; $display("FAIL abort_readback got %h exp cafef00d", rd); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        test_reset();
        test_sw();
        test_loads();
        test_sb();
        test_misalign();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
